mips_alu: RTL and testbench

//  Registered 32-bit integer ALU for the 5-stage MIPS pipeline. It sits on the EX->MM boundary.
//  It decodes opcode/funct, computes one result per cycle from forwarded rs/rt and the 16-bit

---
 rtl/mips_isa_pkg.sv | 46 ++++
 rtl/mips_shifter.sv | 18 +
 rtl/mips_alu.sv | 77 +++++++
 tb/tb_mips_alu.sv | 108 ++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct encodings and shifter kinds shared by the ALU and pipeline decode
package mips_isa_pkg;

    localparam logic [5:0] INST_R        = 6'h00;
    localparam logic [5:0] INST_J_J      = 6'h02;
    localparam logic [5:0] INST_I_BEQ    = 6'h04;
    localparam logic [5:0] INST_I_BNE    = 6'h05;
    localparam logic [5:0] INST_I_ADDI   = 6'h08;
    localparam logic [5:0] INST_I_ADDIU  = 6'h09;
    localparam logic [5:0] INST_I_SLTI   = 6'h0A;
    localparam logic [5:0] INST_I_SLTIU  = 6'h0B;
    localparam logic [5:0] INST_I_ANDI   = 6'h0C;
    localparam logic [5:0] INST_I_ORI    = 6'h0D;
    localparam logic [5:0] INST_I_XORI   = 6'h0E;
    localparam logic [5:0] INST_I_LUI    = 6'h0F;
    localparam logic [5:0] INST_SPECIAL2 = 6'h1C;
    localparam logic [5:0] INST_I_LW     = 6'h23;
    localparam logic [5:0] INST_I_SW     = 6'h2B;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;
    localparam logic [5:0] FUNCT_MUL  = 6'h02;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shift_kind_e;

endpackage

// File: rtl/mips_shifter.sv
// mips_shifter: combinational 32-bit barrel shifter (logical left/right, arithmetic right)
module mips_shifter
    import mips_isa_pkg::*;
(
    input  logic [31:0]  i_data,
    input  logic [4:0]   i_amount,
    input  shift_kind_e  i_kind,
    output logic [31:0]  o_data
);

    // select shift direction; arithmetic right replicates the sign bit
    always_comb begin
        o_data = i_kind == SHIFT_SLL ? i_data << i_amount :
                 i_kind == SHIFT_SRA ? 32'($signed(i_data) >>> i_amount) :
                                       i_data >> i_amount;
    end

endmodule

// File: rtl/mips_alu.sv
// mips_alu: registered 32-bit EX->MM ALU; define ALU_MUL_EN to add SPECIAL2 MUL (low 32 bits)
module mips_alu
    import mips_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt_in,
    input  logic [31:0] rrs,
    input  logic [31:0] rrt_in,
    input  logic [15:0] imm,
    output logic [31:0] rslt
);

    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [4:0]  w_shamt;
    shift_kind_e w_kind;
    logic [31:0] w_shift;
    logic [31:0] w_result;
    logic [31:0] r_rslt;

    assign w_simm  = {{16{imm[15]}}, imm};
    assign w_zimm  = {16'h0000, imm};
    assign w_shamt = funct[2] ? rrs[4:0] : shamt_in;
    assign w_kind  = !funct[1] ? SHIFT_SLL : funct[0] ? SHIFT_SRA : SHIFT_SRL;

    mips_shifter u_shifter (
        .i_data   (rrt_in),
        .i_amount (w_shamt),
        .i_kind   (w_kind),
        .o_data   (w_shift)
    );

    // decode opcode/funct into the next result; anything unlisted yields zero
    always_comb begin
        w_result = '0;
        case (opcode)
            INST_R: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: w_result = rrs + rrt_in;
                    FUNCT_SUB, FUNCT_SUBU: w_result = rrs - rrt_in;
                    FUNCT_AND:  w_result = rrs & rrt_in;
                    FUNCT_OR:   w_result = rrs | rrt_in;
                    FUNCT_XOR:  w_result = rrs ^ rrt_in;
                    FUNCT_NOR:  w_result = ~(rrs | rrt_in);
                    FUNCT_SLT:  w_result = $signed(rrs) < $signed(rrt_in) ? 32'd1 : 32'd0;
                    FUNCT_SLTU: w_result = rrs < rrt_in ? 32'd1 : 32'd0;
                    FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
                    FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: w_result = w_shift;
                    default:    w_result = '0;
                endcase
            end
            INST_I_ADDI, INST_I_ADDIU,
            INST_I_LW, INST_I_SW: w_result = rrs + w_simm;
            INST_I_SLTI:  w_result = $signed(rrs) < $signed(w_simm) ? 32'd1 : 32'd0;
            INST_I_SLTIU: w_result = rrs < w_simm ? 32'd1 : 32'd0;
            INST_I_ANDI:  w_result = rrs & w_zimm;
            INST_I_ORI:   w_result = rrs | w_zimm;
            INST_I_XORI:  w_result = rrs ^ w_zimm;
            INST_I_LUI:   w_result = {imm, 16'h0000};
`ifdef ALU_MUL_EN
            INST_SPECIAL2: w_result = funct == FUNCT_MUL ? rrs * rrt_in : '0;
`endif
            default:      w_result = '0;
        endcase
    end

    // single output register; active-low reset wins over the computed value
    always_ff @(posedge clk) begin
        r_rslt <= !rst ? '0 : w_result;
    end

    assign rslt = r_rslt;

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed-vector self-checking bench for mips_alu (honours ALU_MUL_EN)
module tb_mips_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt_in;
    logic [31:0] rrs;
    logic [31:0] rrt_in;
    logic [15:0] imm;
    logic [31:0] rslt;
    int          checks = 0;
    int          errors = 0;

    mips_alu dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .funct    (funct),
        .shamt_in (shamt_in),
        .rrs      (rrs),
        .rrt_in   (rrt_in),
        .imm      (imm),
        .rslt     (rslt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] im, input logic [31:0] exp);
        opcode = op; funct = fn; shamt_in = sh; rrs = rs; rrt_in = rt; imm = im;
        @(posedge clk);
        #1;
        check(tag, rslt, exp);
    endtask

    initial begin
        rst = 1'b0;
        opcode = 6'h00; funct = 6'h20; shamt_in = 5'd0; rrs = 32'd5; rrt_in = 32'd7; imm = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", rslt, 32'h0);
        rst = 1'b1;
        run("add_after_reset", 6'h00, 6'h20, 5'd0, 32'd5, 32'd7, 16'h0, 32'd12);
        run("sub_wrap",   6'h00, 6'h22, 5'd0, 32'h0, 32'h1, 16'h0, 32'hFFFFFFFF);
        run("addi_wrap",  6'h08, 6'h00, 5'd0, 32'h7FFFFFFF, 32'h0, 16'h0001, 32'h80000000);
        run("lw_addr",    6'h23, 6'h00, 5'd0, 32'h100, 32'h0, 16'hFFFC, 32'h000000FC);
        run("ori_zimm",   6'h0D, 6'h00, 5'd0, 32'hFFFF0000, 32'h0, 16'h8001, 32'hFFFF8001);
        run("lui",        6'h0F, 6'h00, 5'd0, 32'hDEADBEEF, 32'h0, 16'h1234, 32'h12340000);
        run("nor_zero",   6'h00, 6'h27, 5'd0, 32'h0, 32'h0, 16'h0, 32'hFFFFFFFF);
        run("slt_bound",  6'h00, 6'h2A, 5'd0, 32'h80000000, 32'h7FFFFFFF, 16'h0, 32'd1);
        run("sltu_bound", 6'h00, 6'h2B, 5'd0, 32'h80000000, 32'h7FFFFFFF, 16'h0, 32'd0);
        run("sltiu_simm", 6'h0B, 6'h00, 5'd0, 32'd5, 32'h0, 16'hFFFF, 32'd1);
        run("slti_neg",   6'h0A, 6'h00, 5'd0, 32'd5, 32'h0, 16'hFFFF, 32'd0);
        run("sra_31",     6'h00, 6'h03, 5'd31, 32'h0, 32'h80000000, 16'h0, 32'hFFFFFFFF);
        run("srl_31",     6'h00, 6'h02, 5'd31, 32'h0, 32'h80000000, 16'h0, 32'h00000001);
        run("srlv_rs5",   6'h00, 6'h06, 5'd0, 32'h21, 32'h80000000, 16'h0, 32'h40000000);
        run("sll_zero",   6'h00, 6'h00, 5'd0, 32'h0, 32'hA5A5A5A5, 16'h0, 32'hA5A5A5A5);
        run("sllv",       6'h00, 6'h04, 5'd9, 32'h4, 32'h1, 16'h0, 32'h00000010);
        run("srav",       6'h00, 6'h07, 5'd0, 32'h4, 32'hF0000000, 16'h0, 32'hFF000000);
        run("and",        6'h00, 6'h24, 5'd0, 32'h0000F0F0, 32'h0000FF00, 16'h0, 32'h0000F000);
        run("or",         6'h00, 6'h25, 5'd0, 32'h0000F0F0, 32'h0000FF00, 16'h0, 32'h0000FFF0);
        run("xor",        6'h00, 6'h26, 5'd0, 32'h0000FF00, 32'h00000FF0, 16'h0, 32'h0000F0F0);
        run("addu_wrap",  6'h00, 6'h21, 5'd0, 32'hFFFFFFFF, 32'h2, 16'h0, 32'h00000001);
        run("subu",       6'h00, 6'h23, 5'd0, 32'd10, 32'd3, 16'h0, 32'd7);
        run("andi_zimm",  6'h0C, 6'h00, 5'd0, 32'hFFFFFFFF, 32'h0, 16'h8000, 32'h00008000);
        run("xori_zimm",  6'h0E, 6'h00, 5'd0, 32'hFFFF0000, 32'h0, 16'hFFFF, 32'hFFFFFFFF);
        run("addiu_neg",  6'h09, 6'h00, 5'd0, 32'd10, 32'h0, 16'hFFFE, 32'd8);
        run("sw_addr",    6'h2B, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0008, 32'h00000008);
        run("jr_zero",    6'h00, 6'h08, 5'd0, 32'h1234, 32'h1, 16'h0, 32'h0);
        run("add_nz",     6'h00, 6'h20, 5'd0, 32'h1, 32'h1, 16'h0, 32'd2);
        run("jalr_zero",  6'h00, 6'h09, 5'd0, 32'h1234, 32'h1, 16'h0, 32'h0);
        run("ori_nz",     6'h0D, 6'h00, 5'd0, 32'h0, 32'h0, 16'h00AA, 32'h000000AA);
        run("bad_funct",  6'h00, 6'h01, 5'd3, 32'h5, 32'h5, 16'h5, 32'h0);
        run("ori_nz2",    6'h0D, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0055, 32'h00000055);
        run("beq_zero",   6'h04, 6'h00, 5'd0, 32'h5, 32'h5, 16'h0004, 32'h0);
        run("ori_nz3",    6'h0D, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0011, 32'h00000011);
        run("bne_zero",   6'h05, 6'h00, 5'd0, 32'h5, 32'h6, 16'h0004, 32'h0);
        run("ori_nz4",    6'h0D, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0022, 32'h00000022);
        run("j_zero",     6'h02, 6'h20, 5'd0, 32'h5, 32'h6, 16'h1234, 32'h0);
        run("ori_nz5",    6'h0D, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0033, 32'h00000033);
        run("unk_op",     6'h3F, 6'h20, 5'd0, 32'h5, 32'h6, 16'h1234, 32'h0);
        run("ori_nz6",    6'h0D, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0044, 32'h00000044);
`ifdef ALU_MUL_EN
        run("mul",        6'h1C, 6'h02, 5'd0, 32'd3, 32'hFFFFFFFE, 16'h0, 32'hFFFFFFFA);
`else
        run("mul_off",    6'h1C, 6'h02, 5'd0, 32'd3, 32'hFFFFFFFE, 16'h0, 32'h0);
`endif
        run("ori_nz7",    6'h0D, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0066, 32'h00000066);
        rst = 1'b0;
        run("reset_mid",  6'h00, 6'h20, 5'd0, 32'd100, 32'd1, 16'h0, 32'h0);
        rst = 1'b1;
        run("post_reset", 6'h00, 6'h20, 5'd0, 32'd100, 32'd1, 16'h0, 32'd101);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
